// File: rtl/bram_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_master_pkg: state type and default timeout for bram_burst_master.
// Revision 1.0
// ----------------------------------------------------------------------------
package bram_master_pkg;

  localparam int c_default_timeout = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RREQ  = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RHOLD = 3'd3,
    ST_WREQ  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bram_burst_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_burst_master: burst read/write initiator for a single-port BRAM wrapper.
// Revision 1.0
// ----------------------------------------------------------------------------
module bram_burst_master
  import bram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 31,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = c_default_timeout
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_valid
);

  localparam int c_tcnt_w = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);
  localparam logic [c_tcnt_w-1:0]   c_tcnt_one = c_tcnt_w'(1);
  localparam logic [c_tcnt_w-1:0]   c_tcnt_max = c_tcnt_w'(TIMEOUT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic [c_tcnt_w-1:0]     r_tcnt;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    w_timeout;

  // r_tcnt counts completed RWAIT cycles, so this is the TIMEOUT-th one
  assign w_timeout = (r_tcnt == c_tcnt_max);
  assign rd_data   = r_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_addr    = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_din     = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0)  w_state_nxt = ST_DONE;
          else if (cmd_write) w_state_nxt = ST_WREQ;
          else                w_state_nxt = ST_RREQ;
        end
      end
      ST_RREQ: begin
        mem_en      = 1'b1;
        mem_addr    = r_addr;
        w_state_nxt = ST_RWAIT;
      end
      ST_RWAIT: begin
        // a response arriving on the final allowed cycle still wins
        if (mem_valid) begin
          w_state_nxt = ST_RHOLD;
        end else if (w_timeout) begin
          done        = 1'b1;
          err         = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RHOLD: begin
        rd_valid = 1'b1;
        rd_last  = (r_remaining == '0);
        if (rd_ready) w_state_nxt = (r_remaining != '0) ? ST_RREQ : ST_DONE;
      end
      ST_WREQ: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_din  = wr_data;
          mem_addr = r_addr;
          if (r_remaining == c_len_one) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_tcnt      <= '0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
          end
        end
        ST_RREQ: r_tcnt <= '0;
        ST_RWAIT: begin
          if (mem_valid) begin
            r_rd_data   <= mem_dout;
            r_remaining <= r_remaining - c_len_one;
            r_addr      <= r_addr + c_addr_one;
          end else begin
            r_tcnt <= r_tcnt + c_tcnt_one;
          end
        end
        ST_WREQ: begin
          if (wr_valid) begin
            r_remaining <= r_remaining - c_len_one;
            r_addr      <= r_addr + c_addr_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_burst_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bram_burst_master: randomized bench with a BRAM wrapper model and a
// reference memory image. Revision 1.0
// ----------------------------------------------------------------------------
module tb_bram_burst_master;

  localparam int AW = 15;
  localparam int DW = 31;
  localparam int LW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bram_burst_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_valid (mem_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference image: what memory should hold after all DUT writes so far
  logic [DW-1:0] ref_mem [int];
  // Wrapper storage, only ever written through the DUT's mem_* port
  logic [DW-1:0] bram [int];

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    return h[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(int'(a));
  endfunction

  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    if (bram.exists(int'(a))) return bram[int'(a)];
    return init_word(int'(a));
  endfunction

  // Wrapper model: read data appears `lat` cycles after the cycle mem_en was high
  int          lat = 1;
  int          pend;
  logic [AW-1:0] pend_addr;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid <= 1'b0;
      mem_dout  <= '0;
      pend      <= 0;
      pend_addr <= '0;
    end else begin
      mem_valid <= 1'b0;
      if (pend == 1) begin
        mem_valid <= 1'b1;
        mem_dout  <= bram_word(pend_addr);
        pend      <= 0;
      end else if (pend > 1) begin
        pend <= pend - 1;
      end
      if (mem_en && mem_we) bram[int'(mem_addr)] = mem_din;
      if (mem_en && !mem_we && lat > 0) begin
        if (lat == 1) begin
          mem_valid <= 1'b1;
          mem_dout  <= bram_word(mem_addr);
        end else begin
          pend      <= lat - 1;
          pend_addr <= mem_addr;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic issue_cmd(input bit wr, input logic [AW-1:0] base, input int len, output int t0);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = base;
    cmd_len   = LW'(len);
    @(negedge clk);
    check_eq("cmd_ready", cmd_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: rd_ready held high, 1: stall 5 cycles on word 2, 2: random ready.
  // L == 0 models a wrapper that never answers.
  task automatic do_read(input logic [AW-1:0] base, input int len, input int L, input int mode);
    int t0, idx, stall, last_en, last_hs;
    bit seen_done, first_v, prev_en;
    logic [AW-1:0] a;
    lat = L;
    issue_cmd(1'b0, base, len, t0);
    idx = 0; stall = 0; last_en = 0; last_hs = t0;
    seen_done = 0; first_v = 1; prev_en = 0;
    for (int k = 0; k < 400 && !seen_done; k++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = !(idx == 1 && stall < 5);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      a = base + AW'(idx);
      if (mem_en) begin
        check_eq("rd_en_b2b", prev_en, 0);
        check_eq("rd_we", mem_we, 0);
        check_eq("rd_addr", mem_addr, a);
        if (idx == 0) check_eq("rd_first_en", cyc, t0 + 1);
        else if (mode == 0) check_eq("rd_en_spacing", cyc - last_en, L + 2);
        last_en = cyc;
      end
      if (L == 0) check_eq("to_no_rd_valid", rd_valid, 0);
      if (rd_valid) begin
        check_eq("rd_en_in_hold", mem_en, 0);
        check_eq("rd_data", rd_data, exp_word(a));
        check_eq("rd_last", rd_last, (idx == len - 1));
        if (first_v) begin
          check_eq("rd_first_valid", cyc, t0 + 2 + L);
          first_v = 0;
        end
        if (rd_ready) begin idx++; last_hs = cyc; end
        else stall++;
      end
      if (done) begin
        seen_done = 1;
        if (L == 0) begin
          check_eq("to_done_cycle", cyc, t0 + 1 + TO);
          check_eq("to_err", err, 1);
        end else begin
          check_eq("rd_done_cycle", cyc, last_hs + 1);
          check_eq("rd_err", err, 0);
          check_eq("rd_count", idx, len);
        end
      end else begin
        check_eq("rd_err_idle", err, 0);
      end
      prev_en = mem_en;
      @(posedge clk); #1;
    end
    check_eq("rd_done_seen", seen_done, 1);
    rd_ready = 1'b0;
    @(negedge clk);
    check_eq("rd_cmd_ready_after", cmd_ready, 1);
  endtask

  // mode 0: wr_valid continuous, otherwise random gaps
  task automatic do_write(input logic [AW-1:0] base, input int len, input int mode);
    int t0, idx, last_hs;
    bit seen_done;
    logic [AW-1:0] a;
    lat = 1;
    issue_cmd(1'b1, base, len, t0);
    idx = 0; last_hs = t0; seen_done = 0;
    for (int k = 0; k < 400 && !seen_done; k++) begin
      wr_valid = (idx < len) && ((mode == 0) || ($urandom_range(0, 2) != 0));
      wr_data  = DW'($urandom);
      @(negedge clk);
      a = base + AW'(idx);
      if (idx < len) check_eq("wr_ready", wr_ready, 1);
      if (wr_valid && wr_ready) begin
        check_eq("wr_en", mem_en, 1);
        check_eq("wr_we", mem_we, 1);
        check_eq("wr_addr", mem_addr, a);
        check_eq("wr_din", mem_din, wr_data);
        if (mode == 0) check_eq("wr_cycle", cyc, t0 + 1 + idx);
        ref_mem[int'(a)] = wr_data;
        idx++;
        last_hs = cyc;
      end else begin
        check_eq("wr_idle_en", mem_en, 0);
      end
      if (done) begin
        seen_done = 1;
        check_eq("wr_done_cycle", cyc, last_hs + 1);
        check_eq("wr_err", err, 0);
        check_eq("wr_count", idx, len);
      end
      @(posedge clk); #1;
    end
    check_eq("wr_done_seen", seen_done, 1);
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("wr_cmd_ready_after", cmd_ready, 1);
  endtask

  task automatic do_empty(input bit wr);
    int t0;
    issue_cmd(wr, 15'h1234, 0, t0);
    @(negedge clk);
    check_eq("empty_done", done, 1);
    check_eq("empty_err", err, 0);
    check_eq("empty_en", mem_en, 0);
    check_eq("empty_cmd_ready_busy", cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("empty_cmd_ready", cmd_ready, 1);
    check_eq("empty_done_once", done, 0);
  endtask

  task automatic do_reset_mid();
    int t0;
    bit hit;
    hit = 0;
    lat = 2;
    issue_cmd(1'b0, 15'h0100, 4, t0);
    rd_ready = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (rd_valid) hit = 1;
      else begin @(posedge clk); #1; end
    end
    check_eq("rst_reached_hold", hit, 1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_last", rd_last, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_no_done", done, 0);
    check_eq("rst_idle_ready", cmd_ready, 1);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_cmd_ready", cmd_ready, 1);
    check_eq("reset_rd_valid", rd_valid, 0);
    check_eq("reset_wr_ready", wr_ready, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_err", err, 0);
    check_eq("reset_mem_en", mem_en, 0);
    check_eq("reset_mem_we", mem_we, 0);
    check_eq("reset_mem_addr", mem_addr, 0);
    check_eq("reset_mem_din", mem_din, 0);
    check_eq("reset_rd_data", rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    do_read(15'h0010, 4, 3, 0);
    do_read(15'h0200, 4, 1, 1);
    do_write(15'h7FFE, 3, 0);
    do_read(15'h7FFE, 3, 2, 2);
    do_empty(1'b0);
    do_empty(1'b1);
    do_read(15'h0040, 2, 0, 0);
    do_read(15'h0041, 2, 2, 0);

    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] b;
      int n;
      b = ($urandom_range(0, 1) == 1) ? AW'(15'h7FFB + $urandom_range(0, 4))
                                      : AW'($urandom);
      n = $urandom_range(1, 6);
      do_write(b, n, 1);
      do_read(b, n, $urandom_range(1, 4), 2);
      do_read(AW'($urandom), $urandom_range(1, 4), $urandom_range(1, 3), 0);
    end

    do_reset_mid();
    do_read(15'h0100, 3, 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
